// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 16-bit RISC-V pipeline.
// Covers load-use bubbles, wrong-path squash after taken branches, and a
// global freeze while data memory is busy. Also counts lost issue cycles.
module hazard_ctrl #(
  parameter int REG_W        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IFID_RS1,
  input  logic [REG_W-1:0] IFID_RS2,
  input  logic             IFID_usesRS2,
  input  logic [REG_W-1:0] IDEX_RD,
  input  logic             IDEX_memRead,
  input  logic             EX_branchTaken,
  input  logic             mem_busy,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cycles
);

  // Flush counter only needs to hold FLUSH_CYCLES-1.
  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
  localparam logic [FC_W-1:0]  FC_LOAD  = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);
  localparam logic [FC_W-1:0]  FC_ZERO  = FC_W'(0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  // Per-cycle action chosen by the next-state logic, decoded into enables.
  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_FREEZE = 3'd1,
    ACT_BR     = 3'd2,  // first squash cycle: IF/ID and ID/EX both flushed
    ACT_FL     = 3'd3,  // later squash cycles: IF/ID only
    ACT_LU     = 3'd4   // one load-use bubble
  } act_t;

  // A single-cycle flush needs no FLUSH state at all.
  localparam state_t BR_NEXT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  state_t           state_r, state_nxt_s;
  logic [FC_W-1:0]  flush_cnt_r, flush_cnt_nxt_s;
  logic             br_pend_r, br_pend_nxt_s;
  logic             resume_r, resume_nxt_s;   // freeze interrupted a flush
  logic [CNT_W-1:0] stall_cycles_r;
  act_t             act_s;
  logic             lu_s;
  logic             stall_inc_s;

  // x0 is hardwired zero, so a load to x0 never creates a dependency.
  assign lu_s = IDEX_memRead & (IDEX_RD != {REG_W{1'b0}}) &
                ((IDEX_RD == IFID_RS1) | (IFID_usesRS2 & (IDEX_RD == IFID_RS2)));

  assign stall_inc_s  = (~PC_write) | IFID_flush;
  assign stall_cycles = stall_cycles_r;

  // State register, flush bookkeeping and saturating lost-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_RUN;
      flush_cnt_r    <= FC_ZERO;
      br_pend_r      <= 1'b0;
      resume_r       <= 1'b0;
      stall_cycles_r <= CNT_ZERO;
    end else begin
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      br_pend_r   <= br_pend_nxt_s;
      resume_r    <= resume_nxt_s;
      if (stall_inc_s && (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + CNT_ONE;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
    end
  end

  // Next-state logic; also picks the action applied to the enables this cycle.
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    br_pend_nxt_s   = br_pend_r;
    resume_nxt_s    = resume_r;
    act_s           = ACT_NONE;
    case (state_r)
      ST_RUN: begin
        if (mem_busy) begin
          act_s         = ACT_FREEZE;
          state_nxt_s   = ST_MEM_WAIT;
          br_pend_nxt_s = EX_branchTaken;
          resume_nxt_s  = 1'b0;
        end else if (EX_branchTaken) begin
          act_s           = ACT_BR;
          state_nxt_s     = BR_NEXT;
          flush_cnt_nxt_s = FC_LOAD;
        end else if (lu_s) begin
          act_s = ACT_LU;
        end else begin
          act_s = ACT_NONE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          // Load-use is irrelevant while everything holds.
          act_s         = ACT_FREEZE;
          br_pend_nxt_s = br_pend_r | EX_branchTaken;
        end else if (resume_r) begin
          // Pick the interrupted squash up where it stopped.
          act_s           = ACT_FL;
          resume_nxt_s    = 1'b0;
          br_pend_nxt_s   = 1'b0;
          flush_cnt_nxt_s = flush_cnt_r - FC_ONE;
          if (flush_cnt_r == FC_ONE) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_FLUSH;
          end
        end else if (br_pend_r || EX_branchTaken) begin
          act_s           = ACT_BR;
          br_pend_nxt_s   = 1'b0;
          state_nxt_s     = BR_NEXT;
          flush_cnt_nxt_s = FC_LOAD;
        end else if (lu_s) begin
          act_s       = ACT_LU;
          state_nxt_s = ST_RUN;
        end else begin
          act_s       = ACT_NONE;
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (mem_busy) begin
          act_s         = ACT_FREEZE;
          state_nxt_s   = ST_MEM_WAIT;
          resume_nxt_s  = 1'b1;
          br_pend_nxt_s = 1'b0;
        end else begin
          // EX holds a bubble here, so a taken branch cannot occur.
          act_s           = ACT_FL;
          flush_cnt_nxt_s = flush_cnt_r - FC_ONE;
          if (flush_cnt_r == FC_ONE) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_FLUSH;
          end
        end
      end
      default: begin
        state_nxt_s     = ST_RUN;
        flush_cnt_nxt_s = FC_ZERO;
        br_pend_nxt_s   = 1'b0;
        resume_nxt_s    = 1'b0;
        act_s           = ACT_NONE;
      end
    endcase
  end

  // Decode the action into pipeline enables; reset forces a safe bubble pattern.
  always_comb begin
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst_n) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      pipe_freeze = 1'b0;
    end else begin
      case (act_s)
        ACT_FREEZE: begin
          // Freeze dominates: no flushes while MEM cannot complete.
          PC_write    = 1'b0;
          IFID_write  = 1'b0;
          pipe_freeze = 1'b1;
        end
        ACT_BR: begin
          IFID_flush = 1'b1;
          IDEX_flush = 1'b1;
        end
        ACT_FL: begin
          IFID_flush = 1'b1;
        end
        ACT_LU: begin
          PC_write   = 1'b0;
          IFID_write = 1'b0;
          IDEX_flush = 1'b1;
        end
        ACT_NONE: begin
          PC_write = 1'b1;
        end
        default: begin
          PC_write = 1'b1;
        end
      endcase
    end
  end

endmodule
